// File: rtl/mcoc_hexldr_pkg.sv
// Shared types and constants for the hardware hex-text loader.
// Holds the FSM state encoding, the ASCII constants and the character classes.
package mcoc_hexldr_pkg;

    typedef enum logic [2:0] {
        S_SEP = 3'd0,
        S_ADR = 3'd1,
        S_DAT = 3'd2,
        S_WR  = 3'd3,
        S_ERR = 3'd4
    } state_t;

    localparam logic [7:0] CHR_LF  = 8'h0A;
    localparam logic [7:0] CHR_CR  = 8'h0D;
    localparam logic [7:0] CHR_TAB = 8'h09;
    localparam logic [7:0] CHR_SPC = 8'h20;
    localparam logic [7:0] CHR_NUL = 8'h00;
    localparam logic [7:0] CHR_ATM = 8'h40;

    typedef enum logic [2:0] {
        CLS_HEX = 3'd0,
        CLS_SEP = 3'd1,
        CLS_LF  = 3'd2,
        CLS_ATM = 3'd3,
        CLS_BAD = 3'd4
    } cls_t;

endpackage

// File: rtl/mcoc_hex_cls.sv
// Combinational character classifier for the hex loader.
// Reports the class of one byte and, for hex digits, its nibble value.
module mcoc_hex_cls
    import mcoc_hexldr_pkg::*;
(
    input  logic [7:0] chr,
    output cls_t       cls,
    output logic [3:0] nib
);

    always_comb begin
        cls = CLS_BAD;
        nib = '0;
        if (chr >= 8'h30 && chr <= 8'h39) begin
            cls = CLS_HEX;
            nib = chr[3:0];
        end else if ((chr >= 8'h41 && chr <= 8'h46) || (chr >= 8'h61 && chr <= 8'h66)) begin
            // 'A'/'a' have low nibble 1, so adding 9 yields 10..15
            cls = CLS_HEX;
            nib = chr[3:0] + 4'd9;
        end else if (chr == CHR_SPC || chr == CHR_TAB || chr == CHR_CR || chr == CHR_NUL) begin
            cls = CLS_SEP;
        end else if (chr == CHR_LF) begin
            cls = CLS_LF;
        end else if (chr == CHR_ATM) begin
            cls = CLS_ATM;
        end
    end

endmodule

// File: rtl/mcoc_hexldr.sv
// Hardware hex-text loader: parses "@addr" and hex data tokens from a byte
// stream and issues word writes, with error recovery and load statistics.
module mcoc_hexldr
    import mcoc_hexldr_pkg::*;
#(
    parameter int unsigned DWID = 16,
    parameter int unsigned AWID = 16,
    parameter int unsigned CWID = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ena,
    input  logic            clr,
    input  logic [7:0]      rx_dat,
    input  logic            rx_vld,
    output logic            rx_rdy,
    output logic            wr_en,
    output logic [AWID-1:0] wr_adr,
    output logic [DWID-1:0] wr_dat,
    input  logic            wr_ack,
    output logic [AWID-1:0] ptr,
    output logic [CWID-1:0] wcnt,
    output logic [CWID-1:0] lcnt,
    output logic            err,
    output logic [CWID-1:0] err_cnt,
    output logic            busy
);

    localparam int unsigned DDIG = DWID / 4;
    localparam int unsigned ADIG = (AWID + 3) / 4;
    // Accumulator must hold the longer of an address or a data token
    localparam int unsigned ACCW = (DWID > 4 * ADIG) ? DWID : 4 * ADIG;

    state_t          state, nxt_state;
    logic [ACCW-1:0] acc, nxt_acc;
    logic [5:0]      ndig, nxt_ndig;
    logic            lf_term, nxt_lf_term;
    logic [AWID-1:0] nxt_ptr, nxt_wr_adr;
    logic [DWID-1:0] nxt_wr_dat;
    logic [CWID-1:0] nxt_wcnt, nxt_lcnt, nxt_err_cnt;
    logic            nxt_err;

    cls_t       cls;
    logic [3:0] nib;
    logic       take, is_lf, is_term, dig_full, go_err;

    mcoc_hex_cls u_cls (
        .chr (rx_dat),
        .cls (cls),
        .nib (nib)
    );

    assign rx_rdy   = ena & ~rst & ~clr & (state != S_WR);
    assign wr_en    = (state == S_WR);
    assign busy     = (state != S_SEP);
    assign take     = rx_vld & rx_rdy;
    assign is_lf    = (cls == CLS_LF);
    assign is_term  = (cls == CLS_SEP) | is_lf;
    assign dig_full = (state == S_ADR) ? (ndig == 6'(ADIG)) : (ndig == 6'(DDIG));

    always_comb begin
        nxt_state   = state;
        nxt_acc     = acc;
        nxt_ndig    = ndig;
        nxt_lf_term = lf_term;
        nxt_ptr     = ptr;
        nxt_wr_adr  = wr_adr;
        nxt_wr_dat  = wr_dat;
        nxt_wcnt    = wcnt;
        nxt_lcnt    = lcnt;
        nxt_err     = err;
        nxt_err_cnt = err_cnt;
        go_err      = 1'b0;

        if (state == S_WR) begin
            if (wr_ack) begin
                nxt_ptr   = ptr + AWID'(1);
                nxt_wcnt  = wcnt + CWID'(1);
                if (lf_term) nxt_lcnt = lcnt + CWID'(1);
                nxt_state = S_SEP;
            end
        end else if (take) begin
            case (state)
                S_SEP: begin
                    case (cls)
                        CLS_HEX: begin
                            nxt_acc   = ACCW'(nib);
                            nxt_ndig  = 6'd1;
                            nxt_state = S_DAT;
                        end
                        CLS_ATM: begin
                            nxt_acc   = '0;
                            nxt_ndig  = '0;
                            nxt_state = S_ADR;
                        end
                        CLS_SEP: ;
                        CLS_LF:  nxt_lcnt = lcnt + CWID'(1);
                        default: go_err = 1'b1;
                    endcase
                end
                S_ADR, S_DAT: begin
                    if (cls == CLS_HEX) begin
                        if (dig_full) begin
                            go_err = 1'b1;
                        end else begin
                            nxt_acc  = {acc[ACCW-5:0], nib};
                            nxt_ndig = ndig + 6'd1;
                        end
                    end else if (is_term) begin
                        if (state == S_DAT) begin
                            nxt_wr_adr  = ptr;
                            nxt_wr_dat  = acc[DWID-1:0];
                            nxt_lf_term = is_lf;
                            nxt_state   = S_WR;
                        end else if (ndig == 6'd0) begin
                            go_err = 1'b1;
                        end else begin
                            nxt_ptr   = acc[AWID-1:0];
                            nxt_state = S_SEP;
                            if (is_lf) nxt_lcnt = lcnt + CWID'(1);
                        end
                    end else begin
                        go_err = 1'b1;
                    end
                end
                S_ERR: begin
                    if (is_lf) begin
                        nxt_lcnt  = lcnt + CWID'(1);
                        nxt_state = S_SEP;
                    end
                end
                default: nxt_state = S_SEP;
            endcase

            // An LF that triggers the error also closes the line immediately
            if (go_err) begin
                nxt_err = 1'b1;
                if (err_cnt != '1) nxt_err_cnt = err_cnt + CWID'(1);
                if (is_lf) begin
                    nxt_lcnt  = lcnt + CWID'(1);
                    nxt_state = S_SEP;
                end else begin
                    nxt_state = S_ERR;
                end
            end
        end

        if (clr) begin
            nxt_state   = S_SEP;
            nxt_acc     = '0;
            nxt_ndig    = '0;
            nxt_lf_term = 1'b0;
            nxt_ptr     = '0;
            nxt_wcnt    = '0;
            nxt_lcnt    = '0;
            nxt_err     = 1'b0;
            nxt_err_cnt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_SEP;
            acc     <= '0;
            ndig    <= '0;
            lf_term <= 1'b0;
            ptr     <= '0;
            wr_adr  <= '0;
            wr_dat  <= '0;
            wcnt    <= '0;
            lcnt    <= '0;
            err     <= 1'b0;
            err_cnt <= '0;
        end else begin
            state   <= nxt_state;
            acc     <= nxt_acc;
            ndig    <= nxt_ndig;
            lf_term <= nxt_lf_term;
            ptr     <= nxt_ptr;
            wr_adr  <= nxt_wr_adr;
            wr_dat  <= nxt_wr_dat;
            wcnt    <= nxt_wcnt;
            lcnt    <= nxt_lcnt;
            err     <= nxt_err;
            err_cnt <= nxt_err_cnt;
        end
    end

endmodule

// File: tb/tb_mcoc_hexldr.sv
// Directed bench for mcoc_hexldr: a 16-bit data instance plus a 32-bit data
// instance sharing the byte stream, each enabled only while it is under test.
module tb_mcoc_hexldr;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ena = 1'b1;
    logic        ena2 = 1'b0;
    logic        clr = 1'b0;
    logic [7:0]  rx_dat = '0;
    logic        rx_vld = 1'b0;
    logic        wr_ack = 1'b1;

    logic        rx_rdy, wr_en, err, busy;
    logic [15:0] wr_adr, wr_dat, ptr, wcnt, lcnt, err_cnt;

    logic        rx_rdy2, wr_en2, err2, busy2;
    logic [15:0] wr_adr2, ptr2, wcnt2, lcnt2, err_cnt2;
    logic [31:0] wr_dat2;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [15:0] wa[$];
    logic [15:0] wd[$];
    logic [31:0] wd32[$];
    int unsigned wen_cyc = 0;

    always #5 clk = ~clk;

    mcoc_hexldr #(.DWID(16), .AWID(16), .CWID(16)) dut (
        .clk(clk), .rst(rst), .ena(ena), .clr(clr),
        .rx_dat(rx_dat), .rx_vld(rx_vld), .rx_rdy(rx_rdy),
        .wr_en(wr_en), .wr_adr(wr_adr), .wr_dat(wr_dat), .wr_ack(wr_ack),
        .ptr(ptr), .wcnt(wcnt), .lcnt(lcnt), .err(err), .err_cnt(err_cnt), .busy(busy)
    );

    mcoc_hexldr #(.DWID(32), .AWID(16), .CWID(16)) dut32 (
        .clk(clk), .rst(rst), .ena(ena2), .clr(clr),
        .rx_dat(rx_dat), .rx_vld(rx_vld), .rx_rdy(rx_rdy2),
        .wr_en(wr_en2), .wr_adr(wr_adr2), .wr_dat(wr_dat2), .wr_ack(wr_ack),
        .ptr(ptr2), .wcnt(wcnt2), .lcnt(lcnt2), .err(err2), .err_cnt(err_cnt2), .busy(busy2)
    );

    always @(posedge clk) begin
        if (wr_en && wr_ack) begin
            wa.push_back(wr_adr);
            wd.push_back(wr_dat);
        end
        if (wr_en) wen_cyc++;
        if (wr_en2 && wr_ack) wd32.push_back(wr_dat2);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance
    task automatic send(input logic [7:0] b);
        int unsigned n;
        n = 0;
        rx_dat = b;
        rx_vld = 1'b1;
        #1;
        while (!(rx_rdy | rx_rdy2)) begin
            if (n >= 64) begin
                chk("send_rdy", 32'(rx_rdy | rx_rdy2), 32'd1);
                rx_vld = 1'b0;
                return;
            end
            @(negedge clk);
            #1;
            n++;
        end
        @(posedge clk);
        #1 rx_vld = 1'b0;
        @(negedge clk);
    endtask

    task automatic sendstr(input string s);
        for (int i = 0; i < s.len(); i++) send(8'(s[i]));
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int unsigned base;
        int unsigned wen0;

        // Reset state
        idle(2);
        #1;
        chk("rst_rx_rdy", 32'(rx_rdy), 32'd0);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_ptr", 32'(ptr), 32'd0);
        chk("rst_wcnt", 32'(wcnt), 32'd0);
        chk("rst_lcnt", 32'(lcnt), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_rx_rdy", 32'(rx_rdy), 32'd1);
        ena = 1'b0;
        #1;
        chk("ena0_rx_rdy", 32'(rx_rdy), 32'd0);
        ena = 1'b1;
        @(negedge clk);

        // Address plus two data words on one line
        base = wa.size();
        sendstr("@0010 1234 abcd\n");
        idle(3);
        chk("t1_nwr", 32'(wa.size() - base), 32'd2);
        chk("t1_adr0", 32'(wa[base]), 32'h0010);
        chk("t1_dat0", 32'(wd[base]), 32'h1234);
        chk("t1_adr1", 32'(wa[base+1]), 32'h0011);
        chk("t1_dat1", 32'(wd[base+1]), 32'hABCD);
        chk("t1_ptr", 32'(ptr), 32'h0012);
        chk("t1_wcnt", 32'(wcnt), 32'd2);
        chk("t1_lcnt", 32'(lcnt), 32'd1);
        chk("t1_err", 32'(err), 32'd0);

        // Write back-pressure: ack arrives in the fourth wr_en cycle
        pulse_clr();
        base = wa.size();
        wr_ack = 1'b0;
        sendstr("5a5a\n");
        wen0 = wen_cyc;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) wr_ack = 1'b1;
            #1;
            chk("t2_wr_en", 32'(wr_en), 32'd1);
            chk("t2_wr_adr", 32'(wr_adr), 32'h0000);
            chk("t2_wr_dat", 32'(wr_dat), 32'h5A5A);
            chk("t2_rx_rdy", 32'(rx_rdy), 32'd0);
            @(negedge clk);
        end
        #1;
        chk("t2_wr_en_done", 32'(wr_en), 32'd0);
        chk("t2_wen_cycles", 32'(wen_cyc - wen0), 32'd4);
        chk("t2_nwr", 32'(wa.size() - base), 32'd1);
        chk("t2_lcnt", 32'(lcnt), 32'd1);
        chk("t2_ptr", 32'(ptr), 32'd1);
        @(negedge clk);

        // Invalid character discards the rest of the line
        pulse_clr();
        base = wa.size();
        sendstr("12G4 5678\n9\n");
        idle(3);
        chk("t3_err", 32'(err), 32'd1);
        chk("t3_err_cnt", 32'(err_cnt), 32'd1);
        chk("t3_nwr", 32'(wa.size() - base), 32'd1);
        chk("t3_adr", 32'(wa[base]), 32'h0000);
        chk("t3_dat", 32'(wd[base]), 32'h0009);
        chk("t3_lcnt", 32'(lcnt), 32'd2);

        // Five digits overflow a 16-bit word but fit a 32-bit one
        pulse_clr();
        base = wa.size();
        sendstr("12345\n");
        idle(3);
        chk("t4_err_cnt", 32'(err_cnt), 32'd1);
        chk("t4_lcnt", 32'(lcnt), 32'd1);
        chk("t4_nwr", 32'(wa.size() - base), 32'd0);
        ena = 1'b0;
        ena2 = 1'b1;
        pulse_clr();
        base = wd32.size();
        sendstr("12345\n");
        idle(3);
        chk("t4_w32_nwr", 32'(wd32.size() - base), 32'd1);
        chk("t4_w32_dat", wd32[base], 32'h00012345);
        ena2 = 1'b0;
        ena = 1'b1;

        // Pointer wrap, then an empty address token ending the line
        pulse_clr();
        base = wa.size();
        sendstr("@FFFF 1 2\n");
        idle(3);
        chk("t5_nwr", 32'(wa.size() - base), 32'd2);
        chk("t5_adr0", 32'(wa[base]), 32'hFFFF);
        chk("t5_dat0", 32'(wd[base]), 32'h0001);
        chk("t5_adr1", 32'(wa[base+1]), 32'h0000);
        chk("t5_dat1", 32'(wd[base+1]), 32'h0002);
        chk("t5_ptr", 32'(ptr), 32'h0001);
        sendstr("@\n");
        #1;
        chk("t5_at_err_cnt", 32'(err_cnt), 32'd1);
        chk("t5_at_lcnt", 32'(lcnt), 32'd2);
        chk("t5_at_busy", 32'(busy), 32'd0);

        // Blank line with mixed separators
        pulse_clr();
        base = wa.size();
        sendstr("\t \r\n");
        idle(2);
        chk("t6_nwr", 32'(wa.size() - base), 32'd0);
        chk("t6_lcnt", 32'(lcnt), 32'd1);
        chk("t6_wcnt", 32'(wcnt), 32'd0);

        // clr abandons a stalled write
        pulse_clr();
        base = wa.size();
        wr_ack = 1'b0;
        sendstr("7\n");
        #1;
        chk("t7_wr_en", 32'(wr_en), 32'd1);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        #1;
        chk("t7_clr_wr_en", 32'(wr_en), 32'd0);
        chk("t7_clr_busy", 32'(busy), 32'd0);
        chk("t7_clr_wcnt", 32'(wcnt), 32'd0);
        chk("t7_clr_ptr", 32'(ptr), 32'd0);

        // A byte offered alongside clr is not consumed
        @(negedge clk);
        rx_dat = 8'h35;
        rx_vld = 1'b1;
        clr = 1'b1;
        #1;
        chk("t7_clr_rx_rdy", 32'(rx_rdy), 32'd0);
        @(negedge clk);
        rx_vld = 1'b0;
        clr = 1'b0;
        #1;
        chk("t7_clr_byte_busy", 32'(busy), 32'd0);
        @(negedge clk);

        // rst abandons a stalled write and zeroes the latched data
        sendstr("7\n");
        #1;
        chk("t7_wr_dat", 32'(wr_dat), 32'h0007);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t7_rst_wr_en", 32'(wr_en), 32'd0);
        chk("t7_rst_busy", 32'(busy), 32'd0);
        chk("t7_rst_wcnt", 32'(wcnt), 32'd0);
        chk("t7_rst_wr_dat", 32'(wr_dat), 32'h0000);
        chk("t7_nwr", 32'(wa.size() - base), 32'd0);
        wr_ack = 1'b1;
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mcoc_hexldr.md
Name: mcoc_hexldr

Overview:
- Hardware hex-text loader: the successor to the software boot loader. It runs the same "@addr / hex word" line protocol without CPU involvement.
- Consumes a byte stream from the UART receiver (valid/ready), parses whitespace-separated hex tokens, and issues word writes into writable program memory.
- Generalised in data width and address width. Adds error detection/recovery, write back-pressure, and load statistics that the software loader lacks.

Parameters:
- DWID, 16, write-data width in bits; multiple of 4, range 8..32.
- AWID, 16, word-address width of the write port.
- CWID, 16, width of the word/line/error counters.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- ena  in  1  loader enable; when 0, rx_rdy=0 and the parser holds its state.
- clr  in  1  synchronous clear of ptr, counters and err; returns the FSM to S_SEP.
- rx_dat  in  8  received byte.
- rx_vld  in  1  rx_dat valid.
- rx_rdy  out  1  loader accepts a byte this cycle.
- wr_en  out  1  memory write request.
- wr_adr  out  AWID  word address.
- wr_dat  out  DWID  write data.
- wr_ack  in  1  memory accepted the write (same cycle as wr_en is allowed).
- ptr  out  AWID  current write pointer (word address).
- wcnt  out  CWID  words written.
- lcnt  out  CWID  LF characters accepted.
- err  out  1  sticky error flag.
- err_cnt  out  CWID  errored lines, saturating.
- busy  out  1  high in any state other than S_SEP.

Behaviour:
- Reset: all outputs and registers 0; state S_SEP. rx_rdy=0 during the reset cycle and 1 afterwards (when ena=1).
- Byte acceptance: a byte is consumed on a rising edge with rx_vld & rx_rdy. rx_rdy = ena & (state != S_WR).
- Character classes, case-insensitive: hex (0-9, a-f, A-F); sep (space 0x20, tab 0x09, CR 0x0D, NUL 0x00); LF (0x0A); '@' (0x40); anything else is invalid.
- Accumulator acc[DWID-1:0] and digit count ndig[5:0].
- FSM:
  - S_SEP:
    - hex: acc=digit, ndig=1, go S_DAT.
    - '@': acc=0, ndig=0, go S_ADR.
    - sep: stay.
    - LF: lcnt++, stay.
    - invalid: go S_ERR.
  - S_ADR / S_DAT:
    - hex: acc=(acc<<4)|digit, ndig++.
    - ndig would exceed DWID/4 (S_DAT) or ceil(AWID/4) (S_ADR): overflow; go S_ERR, token discarded.
    - sep/LF in S_ADR with ndig>0: ptr=acc[AWID-1:0] (upper bits dropped), go S_SEP; LF also does lcnt++.
    - sep/LF in S_ADR with ndig=0: go S_ERR (LF case: see S_ERR rule below).
    - sep/LF in S_DAT: latch wr_adr=ptr, wr_dat=acc, go S_WR; remember whether the terminator was LF.
    - '@' or invalid: go S_ERR.
  - S_WR:
    - wr_en=1; wr_adr/wr_dat held stable until wr_ack.
    - On wr_ack: ptr++ (wraps 2^AWID-1 -> 0 silently), wcnt++ (wraps); if the remembered terminator was LF, lcnt++; go S_SEP.
  - S_ERR:
    - On entry: err=1, err_cnt++ (saturating).
    - Discard bytes until LF; on LF: lcnt++, go S_SEP.
    - If the byte causing entry is itself LF (e.g. "@\n"): count the error and the line in the same cycle and go directly to S_SEP.
- Latency: terminator accepted at edge n -> wr_en=1 in cycle n+1. With wr_ack tied high, one stall cycle per word; rx_rdy=1 again at cycle n+2.
- Simultaneous events:
  - clr beats everything: an in-progress write is abandoned (wr_en=0 next cycle, no ptr/wcnt update), the partial token is discarded, state becomes S_SEP.
  - A byte presented with clr is not consumed (rx_rdy=0 when clr=1).
  - rst behaves identically to clr and additionally zeroes all outputs.
- ena=0 in S_WR does not suppress wr_en; the write still completes.
- Counters wrap modulo 2^CWID, except err_cnt, which saturates.

Decomposition:
- Package mcoc_hexldr_pkg:
  - state encoding S_SEP, S_ADR, S_DAT, S_WR, S_ERR (3-bit);
  - ASCII constants CHR_LF, CHR_CR, CHR_TAB, CHR_SPC, CHR_NUL, CHR_ATM;
  - character-class enum.
- Sub-module mcoc_hex_cls: combinational 8-bit classifier producing class and 4-bit nibble value. Instantiated once.

Test Plan:
- "@0010 1234 abcd\n", wr_ack=1 -> writes (0x0010,0x1234) then (0x0011,0xABCD); ptr=0x0012, wcnt=2, lcnt=1, err=0.
- "5a5a\n" with wr_ack delayed 3 cycles -> wr_en high 4 cycles; wr_adr/wr_dat stable; rx_rdy=0 throughout; one write; lcnt=1.
- "12G4 5678\n" then "9\n" -> err=1, err_cnt=1, no write from line 1; line 2 writes 0x0009 at the unchanged ptr; lcnt=2.
- "12345\n" -> DWID=16: overflow error, no write. Same stimulus with DWID=32: writes 0x00012345.
- "@FFFF 1 2\n" with AWID=16 -> writes at 0xFFFF then 0x0000; ptr=0x0001. "@\n" -> err_cnt++, lcnt++.
- "\t \r\n" blank line -> no write, lcnt=1. Assert clr (then rst) during S_WR with wr_ack=0 -> wr_en=0 next cycle, wcnt unchanged, state S_SEP.
